// File: rtl/amo_queue.sv
// In-order queue of atomic memory operations between the load/store unit and the D$ AMO port.
// Committed entries (oldest first) are issued one at a time once the store buffer has drained.
module amo_queue #(
  parameter int DEPTH = 2,
  parameter int PLEN  = 56,
  parameter int XLEN  = 64,
  parameter int OPW   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [OPW-1:0]               amo_op_i,
  input  logic [PLEN-1:0]              paddr_i,
  input  logic [XLEN-1:0]              data_i,
  input  logic [1:0]                   size_i,
  input  logic                         commit_i,
  input  logic                         no_st_pending_i,
  output logic                         amo_req_o,
  output logic [OPW-1:0]               amo_op_o,
  output logic [63:0]                  amo_operand_a_o,
  output logic [63:0]                  amo_operand_b_o,
  output logic [1:0]                   amo_size_o,
  input  logic                         amo_ack_i,
  input  logic [63:0]                  amo_result_i,
  output logic                         result_valid_o,
  output logic [63:0]                  result_o,
  output logic [$clog2(DEPTH+1)-1:0]   usage_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ST,
    ISSUE
  } state_t;

  logic [OPW-1:0]  op_mem    [DEPTH];
  logic [PLEN-1:0] paddr_mem [DEPTH];
  logic [XLEN-1:0] data_mem  [DEPTH];
  logic [1:0]      size_mem  [DEPTH];

  logic [PW-1:0] head_q, tail_q, head_d, tail_d, tail_f;
  logic [CW-1:0] count_q, ccnt_q, count_d, ccnt_d, count_p, ccnt_p;
  logic          pop, commit_ok, push_ok;
  state_t        state_q, state_d;

  logic          vld_p1;
  logic [63:0]   result_p1;

  // Pointer advance modulo DEPTH; works for any DEPTH, not just powers of two.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] ptr, input logic [CW-1:0] n);
    int sum;
    sum = int'(ptr) + int'(n);
    if (sum >= DEPTH) sum = sum - DEPTH;
    return PW'(sum);
  endfunction

  assign ready_o = (count_q != FULL);
  assign usage_o = count_q;

  // Events resolve in order pop, commit, flush, push.
  always_comb begin
    pop       = (state_q == ISSUE) && amo_ack_i;
    head_d    = pop ? wrap_add(head_q, CW'(1)) : head_q;
    count_p   = count_q - CW'(pop);
    ccnt_p    = ccnt_q - CW'(pop);
    commit_ok = commit_i && (ccnt_p < count_p);
    ccnt_d    = ccnt_p + CW'(commit_ok);
    tail_f    = flush_i ? wrap_add(head_d, ccnt_d) : tail_q;
    push_ok   = valid_i && ready_o && !flush_i;
    tail_d    = push_ok ? wrap_add(tail_f, CW'(1)) : tail_f;
    count_d   = (flush_i ? ccnt_d : count_p) + CW'(push_ok);
  end

  always_comb begin
    state_d   = state_q;
    amo_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (ccnt_d != '0) state_d = no_st_pending_i ? ISSUE : WAIT_ST;
      end
      WAIT_ST: begin
        if (no_st_pending_i) state_d = ISSUE;
      end
      ISSUE: begin
        amo_req_o = 1'b1;
        if (amo_ack_i) state_d = ((ccnt_d != '0) && no_st_pending_i) ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ccnt_q  <= '0;
      state_q <= IDLE;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ccnt_q  <= ccnt_d;
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      op_mem[tail_q]    <= amo_op_i;
      paddr_mem[tail_q] <= paddr_i;
      data_mem[tail_q]  <= data_i;
      size_mem[tail_q]  <= size_i;
    end
  end

  // Head entry drives the cache operands; zero when the queue is empty.
  assign amo_op_o        = (count_q != '0) ? op_mem[head_q] : '0;
  assign amo_operand_a_o = (count_q != '0) ? 64'(paddr_mem[head_q]) : '0;
  assign amo_operand_b_o = (count_q != '0) ? 64'(data_mem[head_q]) : '0;
  assign amo_size_o      = (count_q != '0) ? size_mem[head_q] : '0;

  // Result stage: captured on ack, presented the following cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
    end else begin
      vld_p1 <= pop;
      if (pop) result_p1 <= amo_result_i;
    end
  end

  assign result_valid_o = vld_p1;
  assign result_o       = result_p1;

endmodule

// File: tb/tb_amo_queue.sv
// Scoreboard bench for amo_queue: a queue-based reference model predicts occupancy, requests
// and results; a negedge monitor compares whatever the DUT presents against it.
module tb_amo_queue;
  localparam int DEPTH = 3;
  localparam int PLEN  = 56;
  localparam int XLEN  = 64;
  localparam int OPW   = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, commit_i = 1'b0;
  logic            no_st_pending_i = 1'b1, amo_ack_i = 1'b0;
  logic [OPW-1:0]  amo_op_i = '0;
  logic [PLEN-1:0] paddr_i = '0;
  logic [XLEN-1:0] data_i = '0;
  logic [1:0]      size_i = '0;
  logic [63:0]     amo_result_i = '0;
  logic            ready_o, amo_req_o, result_valid_o;
  logic [OPW-1:0]  amo_op_o;
  logic [63:0]     amo_operand_a_o, amo_operand_b_o, result_o;
  logic [1:0]      amo_size_o;
  logic [CW-1:0]   usage_o;

  amo_queue #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN), .OPW(OPW)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .amo_op_i(amo_op_i), .paddr_i(paddr_i), .data_i(data_i), .size_i(size_i),
    .commit_i(commit_i), .no_st_pending_i(no_st_pending_i), .amo_req_o(amo_req_o),
    .amo_op_o(amo_op_o), .amo_operand_a_o(amo_operand_a_o), .amo_operand_b_o(amo_operand_b_o),
    .amo_size_o(amo_size_o), .amo_ack_i(amo_ack_i), .amo_result_i(amo_result_i),
    .result_valid_o(result_valid_o), .result_o(result_o), .usage_o(usage_o)
  );

  typedef struct packed {
    logic [OPW-1:0]  op;
    logic [PLEN-1:0] paddr;
    logic [XLEN-1:0] data;
    logic [1:0]      size;
  } ent_t;

  ent_t        mq[$];          // every queued AMO, oldest first
  ent_t        exp_issue[$];   // committed AMOs awaiting their cache handshake
  logic [63:0] exp_result[$];  // results awaiting their result_valid pulse
  int          m_ccnt = 0;
  bit          m_req = 1'b0, m_rv = 1'b0, model_on = 1'b0;
  int          checks = 0, errors = 0;
  ent_t        mon_h, mon_i;
  logic [63:0] mon_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs held during that cycle.
  task automatic model_update();
    int   sz0;
    ent_t e;
    if (rst_i) begin
      mq.delete(); exp_issue.delete(); exp_result.delete();
      m_ccnt = 0; m_req = 1'b0; m_rv = 1'b0; model_on = 1'b1;
    end else begin
      sz0  = mq.size();
      m_rv = m_req && amo_ack_i;
      if (m_rv) begin
        void'(mq.pop_front());
        m_ccnt--;
        exp_result.push_back(amo_result_i);
      end
      if (commit_i) begin
        if (m_ccnt < mq.size()) begin
          exp_issue.push_back(mq[m_ccnt]);
          m_ccnt++;
        end else begin
          errors++;
          $display("FAIL commit_without_entry ccnt=%0d count=%0d", m_ccnt, mq.size());
        end
      end
      if (flush_i) while (mq.size() > m_ccnt) void'(mq.pop_back());
      if (valid_i && sz0 != DEPTH && !flush_i) begin
        e.op = amo_op_i; e.paddr = paddr_i; e.data = data_i; e.size = size_i;
        mq.push_back(e);
      end
      m_req = (m_req && !amo_ack_i) || (m_ccnt > 0 && no_st_pending_i);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst_i = 1'b0; valid_i = 1'b0; commit_i = 1'b0; flush_i = 1'b0; amo_ack_i = 1'b0;
  endtask

  task automatic set_push(input logic [OPW-1:0] o, input logic [PLEN-1:0] a,
                          input logic [XLEN-1:0] d, input logic [1:0] s);
    valid_i = 1'b1; amo_op_i = o; paddr_i = a; data_i = d; size_i = s;
  endtask

  task automatic rand_push();
    set_push(OPW'($urandom), PLEN'({$urandom, $urandom}), {$urandom, $urandom}, 2'($urandom));
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("req", amo_req_o, m_req);
      chk("usage", usage_o, mq.size());
      chk("ready", ready_o, mq.size() != DEPTH);
      chk("result_valid", result_valid_o, m_rv);
      mon_h = (mq.size() > 0) ? mq[0] : '0;
      chk("head_op", amo_op_o, mon_h.op);
      chk("head_a", amo_operand_a_o, 64'(mon_h.paddr));
      chk("head_b", amo_operand_b_o, 64'(mon_h.data));
      chk("head_size", amo_size_o, mon_h.size);
      if (result_valid_o) begin
        if (exp_result.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_spurious actual=%0h required=none", result_o);
        end else begin
          mon_r = exp_result.pop_front();
          chk("result", result_o, mon_r);
        end
      end
      if (amo_req_o && amo_ack_i) begin
        if (exp_issue.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_spurious actual=%0h required=none", amo_operand_a_o);
        end else begin
          mon_i = exp_issue.pop_front();
          chk("issue_op", amo_op_o, mon_i.op);
          chk("issue_a", amo_operand_a_o, 64'(mon_i.paddr));
          chk("issue_b", amo_operand_b_o, 64'(mon_i.data));
        end
      end
    end
  end

  initial begin
    step(); step(); idle();
    chk("rst_ready", ready_o, 1);
    chk("rst_req", amo_req_o, 0);
    chk("rst_rv", result_valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_usage", usage_o, 0);
    chk("rst_opa", amo_operand_a_o, 0);

    // single AMO end to end
    set_push(4'd2, 56'h1000, 64'h5, 2'd3); step(); idle();
    commit_i = 1'b1; step(); idle();
    chk("t1_req", amo_req_o, 1);
    chk("t1_opa", amo_operand_a_o, 64'h1000);
    amo_ack_i = 1'b1; amo_result_i = 64'hAB; step(); idle();
    chk("t1_rv", result_valid_o, 1);
    chk("t1_result", result_o, 64'hAB);
    chk("t1_usage", usage_o, 0);
    step();
    chk("t1_rv_pulse", result_valid_o, 0);

    // overfill, then free one slot
    for (int i = 0; i <= DEPTH; i++) begin rand_push(); step(); end
    idle();
    chk("t2_ready_full", ready_o, 0);
    chk("t2_usage_full", usage_o, DEPTH);
    commit_i = 1'b1; step(); idle();
    chk("t2_req", amo_req_o, 1);
    amo_ack_i = 1'b1; amo_result_i = {$urandom, $urandom}; step(); idle();
    chk("t2_ready_after_pop", ready_o, 1);
    chk("t2_usage_after_pop", usage_o, DEPTH - 1);
    flush_i = 1'b1; step(); idle();
    chk("t2_usage_flushed", usage_o, 0);

    // flush keeps only the committed entry; later pushes wrap
    set_push(4'd1, 56'h2000, 64'h11, 2'd2); step();
    set_push(4'd3, 56'h3000, 64'h22, 2'd2); step(); idle();
    commit_i = 1'b1; step(); idle();
    flush_i = 1'b1; step(); idle();
    chk("t3_usage", usage_o, 1);
    chk("t3_opa", amo_operand_a_o, 64'h2000);
    amo_ack_i = 1'b1; amo_result_i = 64'h77; step(); idle();
    set_push(4'd5, 56'h4000, 64'h33, 2'd1); step();
    set_push(4'd6, 56'h5000, 64'h44, 2'd1); step(); idle();
    chk("t3_usage_wrap", usage_o, 2);
    chk("t3_opa_wrap", amo_operand_a_o, 64'h4000);
    flush_i = 1'b1; step(); idle();

    // store buffer not drained: hold in wait
    rand_push(); step(); idle();
    no_st_pending_i = 1'b0; commit_i = 1'b1; step(); idle();
    for (int i = 0; i < 5; i++) begin step(); chk("t4_req_wait", amo_req_o, 0); end
    no_st_pending_i = 1'b1; step();
    chk("t4_req_go", amo_req_o, 1);
    amo_ack_i = 1'b1; amo_result_i = {$urandom, $urandom}; step(); idle();

    // commit+flush keeps the entry; push+flush drops the push
    rand_push(); step(); idle();
    commit_i = 1'b1; flush_i = 1'b1; step(); idle();
    chk("t5_usage_kept", usage_o, 1);
    chk("t5_req", amo_req_o, 1);
    amo_ack_i = 1'b1; amo_result_i = {$urandom, $urandom}; step(); idle();
    rand_push(); flush_i = 1'b1; step(); idle();
    chk("t5_push_dropped", usage_o, 0);

    // reset during an outstanding request, then a late ack
    rand_push(); step(); idle();
    commit_i = 1'b1; step(); idle();
    chk("t6_req", amo_req_o, 1);
    rst_i = 1'b1; step(); idle();
    chk("t6_req_off", amo_req_o, 0);
    chk("t6_usage", usage_o, 0);
    chk("t6_ready", ready_o, 1);
    amo_ack_i = 1'b1; amo_result_i = 64'hDEAD; step(); idle();
    chk("t6_late_ack_rv", result_valid_o, 0);
    chk("t6_result", result_o, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      if ($urandom_range(0, 1) == 1) rand_push();
      commit_i        = (m_ccnt < mq.size()) && ($urandom_range(0, 99) < 40);
      flush_i         = ($urandom_range(0, 99) < 8);
      no_st_pending_i = ($urandom_range(0, 99) < 70);
      amo_ack_i       = m_req ? ($urandom_range(0, 99) < 40) : ($urandom_range(0, 99) < 10);
      amo_result_i    = {$urandom, $urandom};
      rst_i           = ($urandom_range(0, 199) == 0);
      if (rst_i) amo_ack_i = 1'b0;
      step();
    end

    // drain everything left
    idle();
    no_st_pending_i = 1'b1;
    for (int n = 0; n < 200 && mq.size() > 0; n++) begin
      commit_i     = (m_ccnt < mq.size());
      amo_ack_i    = m_req;
      amo_result_i = {$urandom, $urandom};
      step(); idle();
    end
    if (mq.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d required=0", mq.size());
    end
    step(); step();
    chk("sb_results_left", exp_result.size(), 0);
    chk("sb_issues_left", exp_issue.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
